// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock FIFO with flop-array storage and asynchronous array read.
//   Occupancy, full/empty and programmable almost-full/almost-empty flags
//   are all decoded from the registered read/write pointers, so no
//   combinational path exists from wr_en/rd_en to any status output.
//   Overflow/underflow are sticky and are cleared only by rst or flush.
//   FWFT=0 : data_out/rd_valid are registered one cycle after an accepted read.
//   FWFT=1 : head word is presented combinationally; rd_valid = ~empty and
//            rd_en pops the word currently shown.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   flush            synchronous clear of contents and error flags
//   wr_en, data_in   write request / data
//   rd_en            read (pop) request
//   data_out         read data
//   rd_valid         data_out holds valid read data
//   full, empty      count == DEPTH / count == 0
//   almost_full      count >= AF_THRESH
//   almost_empty     count <= AE_THRESH
//   count            occupancy 0..DEPTH
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = 60,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic                  wr_acc, rd_acc;

  // Pointers carry one extra wrap bit, so the modular difference is the
  // occupancy and distinguishes full (DEPTH) from empty (0).
  assign count        = wptr - rptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance looks only at this cycle's flags: a write at full is dropped
  // even if a read frees a slot on the same edge, and vice versa at empty.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)         wptr      <= wptr + 1'b1;
      if (rd_acc)         rptr      <= rptr + 1'b1;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is never cleared; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rptr[ADDR_WIDTH-1:0]];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  vld_q;

      // data_out holds its last value between reads; flush drops only valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else if (flush) begin
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rptr[ADDR_WIDTH-1:0]];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = vld_q;
    end
  endgenerate

endmodule
